// File: rtl/decim_output_packer_if.sv
// decim_output_packer_if: sample input stream and packed-word output stream of decim_output_packer
interface decim_output_packer_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8,
    parameter int PACK      = 4
);
    logic                      valid_in;
    logic [IN_WIDTH-1:0]       data_in;
    logic                      m_valid;
    logic                      m_ready;
    logic [PACK*OUT_WIDTH-1:0] m_data;

    modport master (output valid_in, data_in, m_ready, input m_valid, m_data);
    modport slave  (input valid_in, data_in, m_ready, output m_valid, m_data);
endinterface

// File: rtl/decim_output_packer.sv
// decim_output_packer: requantize decimated samples, pack PACK lanes per word, buffer words in a FIFO
// Optional macro DECIM_PACK_ROUND_EN: round half toward +inf before the shift instead of flooring.
module decim_output_packer #(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 8,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    decim_output_packer_if.slave        bus,
    input  logic                        clear_ovf,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int LW = PACK > 1 ? $clog2(PACK) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int WW = PACK * OUT_WIDTH;
    localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [IN_WIDTH:0] SAT_MIN = (IN_WIDTH+1)'(-(1 << (OUT_WIDTH-1)));
`ifdef DECIM_PACK_ROUND_EN
    localparam logic signed [IN_WIDTH:0] HALF = (IN_WIDTH+1)'(1 << (SHIFT-1));
`endif

    logic signed [IN_WIDTH:0] ext, biased, shifted;
    logic [OUT_WIDTH-1:0]     q_d, q_q;
    logic                     valid_q;
    logic [LW-1:0]            lane_d, lane_q;
    logic [WW-1:0]            word_d, word_q;
    logic [WW-1:0]            mem_q [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [PW:0]              level_d, level_q;
    logic                     overflow_d, overflow_q;
    logic                     last, push, pop, full, accept, drop;

    // Requantize one extra bit wide so the rounding bias and the shift can never wrap
    always_comb begin
        ext = {bus.data_in[IN_WIDTH-1], bus.data_in};
`ifdef DECIM_PACK_ROUND_EN
        biased = ext + HALF;
`else
        biased = ext;
`endif
        shifted = biased >>> SHIFT;
        q_d = shifted > SAT_MAX ? SAT_MAX[OUT_WIDTH-1:0] :
              shifted < SAT_MIN ? SAT_MIN[OUT_WIDTH-1:0] : shifted[OUT_WIDTH-1:0];
    end

    // Stage 1: register the requantized sample with its valid flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            q_q     <= '0;
        end else begin
            valid_q <= bus.valid_in;
            if (bus.valid_in) q_q <= q_d;
        end
    end

    // Lane insertion, FIFO push/pop arbitration and sticky overflow next state
    always_comb begin
        word_d = word_q;
        word_d[int'(lane_q)*OUT_WIDTH +: OUT_WIDTH] = q_q;
        last       = lane_q == LW'(PACK-1);
        push       = valid_q && last;
        pop        = bus.m_valid && bus.m_ready;
        full       = level_q == (PW+1)'(FIFO_DEPTH);
        accept     = push && (!full || pop);
        drop       = push && !accept;
        lane_d     = !valid_q ? lane_q : last ? '0 : lane_q + LW'(1);
        level_d    = level_q + (PW+1)'(accept) - (PW+1)'(pop);
        overflow_d = drop || (overflow_q && !clear_ovf);
    end

    // Stage 2: lane counter, partial word, FIFO pointers/level and overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q     <= '0;
            word_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            if (valid_q) word_q <= word_d;
            wr_ptr_q   <= wr_ptr_q + PW'(accept);
            rd_ptr_q   <= rd_ptr_q + PW'(pop);
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Word storage; a push into a full FIFO with a pop reuses the slot being vacated
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= word_d;
    end

    assign bus.m_valid = level_q != '0;
    assign bus.m_data  = bus.m_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow    = overflow_q;
    assign fifo_level  = level_q;
endmodule

// File: doc/decim_output_packer.md
DECIM_OUTPUT_PACKER -- requirements
Module: decim_output_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16: signed width of decimator output samples.
REQ-002 SHALL have parameter OUT_WIDTH, default 8: signed width of requantized samples.
REQ-003 SHALL have parameter SHIFT, default 8: arithmetic right shift applied during requantization; range 1..IN_WIDTH-1.
REQ-004 SHALL have parameter PACK, default 4: samples per output word.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8: output word FIFO depth; power of two, at least 2.
REQ-006 SHALL have port clk, input, 1 bit: clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-008 SHALL have port valid_in, input, 1 bit: data_in holds a new decimated sample this cycle; there is no backpressure.
REQ-009 SHALL have port data_in, input, IN_WIDTH bits: signed two's-complement sample.
REQ-010 SHALL have port m_valid, output, 1 bit: m_data holds a valid packed word.
REQ-011 SHALL have port m_ready, input, 1 bit: downstream accepts the word.
REQ-012 SHALL have port m_data, output, PACK*OUT_WIDTH bits: packed word; sample k of the word occupies bits [k*OUT_WIDTH +: OUT_WIDTH].
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when a completed word is dropped.
REQ-014 SHALL have port clear_ovf, input, 1 bit: synchronous clear of overflow.
REQ-015 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: number of words stored.

Function
REQ-016 Stage 1 SHALL register q = sat(data_in >>> SHIFT) to OUT_WIDTH signed bits on each valid_in, together with a registered valid_q.
REQ-017 Saturation SHALL clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and intermediate results SHALL be computed in IN_WIDTH+1 bits so they never wrap.
REQ-018 Stage 2 SHALL keep a lane counter 0..PACK-1; each valid_q SHALL write q into lane [lane] and increment the counter, wrapping from PACK-1 to 0.
REQ-019 When valid_q arrives with lane==PACK-1, the completed word (previous lanes plus the current q) SHALL be pushed into the FIFO on that same edge.
REQ-020 Latency SHALL be 2 cycles: with the FIFO empty and the last sample of a word on valid_in at edge t, m_valid SHALL be high after edge t+2.
REQ-021 A push SHALL be accepted if fifo_level<FIFO_DEPTH, or if a pop occurs in the same cycle; otherwise the word SHALL be dropped, overflow set to 1, and the lane counter still wrap to 0.
REQ-022 m_valid SHALL equal (fifo_level!=0), and m_data SHALL be the oldest stored word.
REQ-023 A pop SHALL occur when m_valid&&m_ready, and words SHALL leave the FIFO in push order.
REQ-024 m_data SHALL stay stable while m_valid&&!m_ready.
REQ-025 Simultaneous push and pop SHALL leave fifo_level unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 clear_ovf SHALL clear overflow on the next edge unless a drop occurs in the same cycle, in which case overflow SHALL remain 1.

Reset
REQ-027 On reset, m_valid, overflow, fifo_level, the lane counter, the pointers and valid_q SHALL be 0, and m_data SHALL be 0.
REQ-028 Reset mid-word SHALL discard the partial word; the first valid sample after reset SHALL land in lane 0.

Configuration
REQ-029 With DECIM_PACK_ROUND_EN defined, stage 1 SHALL add 2^(SHIFT-1) before the shift (round half toward +infinity) and then saturate.
REQ-030 Without DECIM_PACK_ROUND_EN, stage 1 SHALL truncate (floor); latency and all other behaviour SHALL be identical in both builds.

Verification
REQ-031 Packing: data_in 0x0100, 0x0200, 0x0300, 0x0400 on consecutive cycles with m_ready=1 -> m_data=0x04030201, m_valid high 2 cycles after the last sample for 1 cycle.
REQ-032 Requantization: data_in 0x12C0 -> lane value 0x12 without DECIM_PACK_ROUND_EN and 0x13 with it; data_in 0x7F80 -> 0x7F in both builds; data_in 0x8000 -> 0x80; data_in 0x9000 -> 0x90.
REQ-033 Overflow: m_ready=0 while 9 words are pushed -> fifo_level=8, overflow=1; draining then yields words 1..8 in order and the 9th is absent; clear_ovf -> overflow=0.
REQ-034 Backpressure: m_ready toggled pseudo-randomly over 100 words -> no loss or duplication, and m_data stable whenever m_valid=1 and m_ready=0.
REQ-035 Reset mid-word: 2 samples, reset pulse, then 4 samples 0x0500..0x0800 -> exactly one word, 0x08070605, and overflow=0.
REQ-036 Full with simultaneous pop: FIFO full and m_ready=1 in the cycle a word completes -> push accepted, fifo_level stays 8, overflow stays 0.
